// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter between NREQ byte sources
//
// Each source owns a 1-deep holding register. One held byte at a time is
// granted, presented on tx_data and started with tx_start. The transmitter
// reports idle/busy on tx_finish (clk_uart domain, high = idle). That signal
// is synchronised into sys_clk, and both handshake phases are guarded by a
// watchdog.
//
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin selection.
// When it is undefined, selection is fixed priority (lowest index wins).
//
// Ports:
//   sys_clk      in   system clock
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   [NREQ]    per-source byte offered
//   req_data     in   [8*NREQ]  per-source byte, source i on [8i+7:8i]
//   req_ready    out  [NREQ]    holding register i empty
//   tx_start     out  start strobe to the transmitter
//   tx_data      out  [8]       byte to the transmitter
//   tx_finish    in   transmitter idle (1) / sending (0), asynchronous
//   busy         out  arbiter not idle
//   grant_id     out  [2]       source being sent, valid while busy
//   timeout_err  out  sticky watchdog error, cleared only by reset

module uart_tx_arbiter #(
    parameter int NREQ          = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int START_TIMEOUT = 4000,
    parameter int DONE_TIMEOUT  = 20000
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_finish,
    output logic                busy,
    output logic [1:0]          grant_id,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_START,
        ST_DONE
    } state_t;

    // The watchdog is tested in the cycle it would reach its limit, so each
    // phase lasts at most exactly the configured number of cycles.
    localparam logic [15:0] START_LIM = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] DONE_LIM  = 16'(DONE_TIMEOUT - 1);

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fin_s;
    logic [NREQ-1:0]        full;
    logic [7:0]             hold [NREQ];
    logic [15:0]            wdog;
    logic [1:0]             win;
    logic                   do_grant;
    logic                   wdog_clr;
    logic                   wdog_inc;
    logic                   set_err;
    logic                   start_clr;

    // tx_finish synchroniser; resets to 1 so the transmitter is assumed idle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tx_finish};
        end
    end

    assign fin_s = sync_q[SYNC_STAGES-1];

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_grant;

    // Starts at NREQ-1 so that source 0 is searched first after reset.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 2'(NREQ - 1);
        end else if (do_grant) begin
            last_grant <= win;
        end
    end

    // Search begins at the source after the previous winner, wrapping round.
    always_comb begin
        int   idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && full[idx]) begin
                win   = 2'(idx);
                found = 1'b1;
            end
        end
    end
`else
    // Scanning downwards lets the lowest full index overwrite the others.
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (full[i]) begin
                win = 2'(i);
            end
        end
    end
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        wdog_clr   = 1'b0;
        wdog_inc   = 1'b0;
        set_err    = 1'b0;
        start_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((|full) && fin_s) begin
                    state_next = ST_ARB;
                end
            end
            ST_ARB: begin
                do_grant   = 1'b1;
                wdog_clr   = 1'b1;
                state_next = ST_START;
            end
            ST_START: begin
                if (!fin_s) begin
                    start_clr  = 1'b1;
                    wdog_clr   = 1'b1;
                    state_next = ST_DONE;
                end else if (wdog >= START_LIM) begin
                    // The byte is dropped; the queue moves on to the next one.
                    start_clr  = 1'b1;
                    set_err    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    wdog_inc = 1'b1;
                end
            end
            ST_DONE: begin
                if (fin_s) begin
                    state_next = ST_IDLE;
                end else if (wdog >= DONE_LIM) begin
                    set_err    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    wdog_inc = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog        <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= 2'd0;
            timeout_err <= 1'b0;
        end else begin
            if (wdog_clr) begin
                wdog <= '0;
            end else if (wdog_inc && (wdog != 16'hFFFF)) begin
                wdog <= wdog + 16'd1;
            end

            // tx_data and grant_id hold their value until the next grant,
            // which keeps the byte stable through the whole handshake.
            if (do_grant) begin
                tx_data  <= hold[win];
                grant_id <= win;
                tx_start <= 1'b1;
            end else if (start_clr) begin
                tx_start <= 1'b0;
            end

            if (set_err) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Capture and release never collide on one source: a full register is
    // not ready, so it cannot be refilled in the cycle it is granted.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
            for (int i = 0; i < NREQ; i++) begin
                hold[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !full[i]) begin
                    hold[i] <= req_data[8*i +: 8];
                    full[i] <= 1'b1;
                end else if (do_grant && (win == 2'(i))) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    assign req_ready = ~full;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NREQ     = 3;
    localparam int SYNC     = 2;
    localparam int START_TO = 50;
    localparam int DONE_TO  = 400;
    localparam int DROP     = 10;
    localparam int SEND     = 120;

    logic                sys_clk   = 1'b0;
    logic                rst_n     = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [8*NREQ-1:0]   req_data  = '0;
    logic [NREQ-1:0]     req_ready;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic                tx_finish = 1'b1;
    logic                busy;
    logic [1:0]          grant_id;
    logic                timeout_err;

    uart_tx_arbiter #(
        .NREQ          (NREQ),
        .SYNC_STAGES   (SYNC),
        .START_TIMEOUT (START_TO),
        .DONE_TIMEOUT  (DONE_TO)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_finish   (tx_finish),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t e;
    logic pend_v [NREQ];
    logic [7:0] pend_d [NREQ];
    int   last_g;
    int   uart_mode = 0;
    logic uart_busy = 1'b0;
    logic prev_start = 1'b0;
    int   hi_len = 0;
    int   last_hi_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference model: pending bytes per source plus the arbitration rule.
    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        last_g = NREQ - 1;
    endtask

    task automatic model_add(input logic [NREQ-1:0] m, input logic [8*NREQ-1:0] d);
        for (int i = 0; i < NREQ; i++) begin
            if (m[i]) begin
                pend_v[i] = 1'b1;
                pend_d[i] = d[8*i +: 8];
            end
        end
    endtask

    function automatic int model_pick();
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NREQ; k++) begin
            if (pend_v[(last_g + k) % NREQ]) return (last_g + k) % NREQ;
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (pend_v[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_drain(input bit only_one);
        int w;
        w = model_pick();
        while (w >= 0) begin
            exp_q.push_back({2'(w), pend_d[w]});
            pend_v[w] = 1'b0;
            last_g = w;
            w = only_one ? -1 : model_pick();
        end
    endtask

    // UART_TX model: mode 0 normal, 1 never starts, 2 never finishes.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (tx_start && uart_mode != 1) begin
                uart_busy = 1'b1;
                repeat (DROP) @(negedge sys_clk);
                tx_finish = 1'b0;
                if (uart_mode == 2) wait (uart_mode != 2);
                else repeat (SEND) @(negedge sys_clk);
                tx_finish = 1'b1;
                uart_busy = 1'b0;
            end
        end
    end

    // Monitor: every tx_start rise must match the head of the scoreboard.
    always @(negedge sys_clk) begin
        if (tx_start) hi_len++;
        else begin
            if (prev_start) last_hi_len = hi_len;
            hi_len = 0;
        end
        if (tx_start && !prev_start) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tx_start", tx_start, 0);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", tx_data, e.data);
                check("grant_id", grant_id, e.id);
                check("busy_on_start", busy, 1);
                check("ready_after_arb", req_ready[grant_id], 1);
            end
        end
        prev_start = tx_start;
    end

    task automatic offer(input logic [NREQ-1:0] m, input logic [8*NREQ-1:0] d);
        @(negedge sys_clk);
        req_valid = m;
        req_data  = d;
        @(negedge sys_clk);
        req_valid = '0;
    endtask

    task automatic wait_level(input logic lvl, input string name, input int lim);
        int n;
        n = 0;
        while (tx_start !== lvl && n < lim) begin
            @(negedge sys_clk);
            n++;
        end
        check(name, n < lim, 1);
        #1;
    endtask

    task automatic wait_idle(input string name, input int lim);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || !tx_finish || uart_busy) && n < lim) begin
            @(negedge sys_clk);
            n++;
        end
        check(name, n < lim, 1);
        repeat (SYNC + 2) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0]   m;
        logic [8*NREQ-1:0] d;
        int n;

        model_reset();
        #1;
        check("rst_req_ready", req_ready, 3'b111);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_timeout_err", timeout_err, 0);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);

        // Single byte from source 1.
        d = {8'h00, 8'hA5, 8'h00};
        offer(3'b010, d);
        model_add(3'b010, d);
        model_drain(0);
        wait_level(1'b1, "single_rise", 20);
        wait_level(1'b0, "single_fall", DROP + SYNC + 20);
        check("single_start_len", (last_hi_len >= DROP + SYNC) && (last_hi_len <= DROP + SYNC + 2), 1);
        wait_idle("single_idle", SEND + 100);
        check("single_busy_low", busy, 0);
        check("single_no_err", timeout_err, 0);

        // Contention with a refill of source 0 during the first send.
        do_reset();
        d = {8'h30, 8'h20, 8'h10};
        offer(3'b111, d);
        model_add(3'b111, d);
        model_drain(1);
        n = 0;
        while (!req_ready[0] && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        check("refill_ready", req_ready[0], 1);
        d = {8'h00, 8'h00, 8'h11};
        offer(3'b001, d);
        model_add(3'b001, d);
        model_drain(0);
        wait_idle("contention_idle", 5 * (SEND + DROP + 20));

        // Randomized rounds of simultaneous offers.
        for (int r = 0; r < 6; r++) begin
            m = NREQ'($urandom_range(1, 7));
            d = (8*NREQ)'($urandom);
            offer(m, d);
            model_add(m, d);
            model_drain(0);
            wait_idle("random_idle", NREQ * (SEND + DROP + 20) + 50);
        end

        // Start timeout: transmitter never leaves idle.
        uart_mode = 1;
        d = (8*NREQ)'($urandom);
        offer(3'b110, d);
        model_add(3'b110, d);
        model_drain(0);
        wait_level(1'b1, "sto_rise", 20);
        wait_level(1'b0, "sto_fall", START_TO + 20);
        check("sto_start_len", last_hi_len, START_TO);
        check("sto_err", timeout_err, 1);
        wait_idle("sto_idle", 2 * START_TO + 100);
        check("sto_err_sticky", timeout_err, 1);
        check("sto_busy", busy, 0);
        uart_mode = 0;

        // Done timeout: transmitter never returns to idle.
        do_reset();
        check("dto_err_cleared", timeout_err, 0);
        uart_mode = 2;
        d = {8'h5C, 8'h00, 8'h00};
        offer(3'b100, d);
        model_add(3'b100, d);
        model_drain(0);
        wait_level(1'b1, "dto_rise", 20);
        wait_level(1'b0, "dto_fall", DROP + SYNC + 20);
        n = 0;
        while (busy && n < DONE_TO + 50) begin
            n++;
            @(negedge sys_clk);
        end
        check("dto_done_len", n, DONE_TO);
        check("dto_err", timeout_err, 1);
        check("dto_busy", busy, 0);
        uart_mode = 0;
        wait_idle("dto_idle", 100);

        // Reset in the middle of DONE discards held bytes.
        d = {8'h03, 8'h02, 8'h01};
        offer(3'b111, d);
        model_add(3'b111, d);
        model_drain(0);
        wait_level(1'b1, "mid_rise", 20);
        wait_level(1'b0, "mid_fall", DROP + SYNC + 20);
        repeat (5) @(negedge sys_clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("mid_tx_start", tx_start, 0);
        check("mid_req_ready", req_ready, 3'b111);
        check("mid_timeout_err", timeout_err, 0);
        check("mid_busy", busy, 0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 2 * SEND; c++) begin
            @(negedge sys_clk);
            if (busy) n++;
        end
        check("mid_discarded", n, 0);
        wait_idle("mid_idle", SEND + 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
